// File: rtl/ram_responder_if.sv
// ram_responder_if
//   CPU <-> RAM request/ack bus.
//   master modport: the CPU side, which drives address, write data and the
//                   request pulses and observes data, acks and error flags.
//   slave modport:  the memory side (ram_responder).
//   Signals:
//     ramAddress  32  byte address, bits [1:0] ignored by the memory
//     ramOut      32  write data from CPU
//     readReq      1  read request pulse
//     writeReq     1  write request pulse
//     ramIn       32  read data to CPU
//     readAck      1  one-cycle read-complete pulse
//     writeAck     1  one-cycle write-complete pulse
//     busy         1  a request is in flight
//     addrErr      1  one-cycle pulse alongside an out-of-range ack
//     protoErr     1  sticky protocol-violation flag
interface ram_responder_if;
    logic [31:0] ramAddress;
    logic [31:0] ramOut;
    logic        readReq;
    logic        writeReq;
    logic [31:0] ramIn;
    logic        readAck;
    logic        writeAck;
    logic        busy;
    logic        addrErr;
    logic        protoErr;

    modport master (
        output ramAddress, ramOut, readReq, writeReq,
        input  ramIn, readAck, writeAck, busy, addrErr, protoErr
    );

    modport slave (
        input  ramAddress, ramOut, readReq, writeReq,
        output ramIn, readAck, writeAck, busy, addrErr, protoErr
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder
//   Memory-side end of the CPU RAM request/ack bus. A single-cycle readReq or
//   writeReq is captured in IDLE, serviced from an internal word array after
//   LATENCY cycles, and answered with a one-cycle readAck/writeAck. A side load
//   port preloads the array while the responder is idle.
//   Ports:
//     clk       clock
//     reset     asynchronous, active-high reset (array contents are kept)
//     bus       ram_responder_if.slave, the CPU request/ack bus
//     loadEn    side-port write enable, honoured only in IDLE with no request
//     loadAddr  side-port word address
//     loadData  side-port write data
//   Parameters:
//     DEPTH_LOG2  log2 of the word count
//     LATENCY     request-sampling edge to ack edge, 1..15
//     OOR_DATA    read data returned for out-of-range addresses
module ram_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] OOR_DATA   = 32'hdeadbeef
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_responder_if.slave        bus,
    input  logic                  loadEn,
    input  logic [DEPTH_LOG2-1:0] loadAddr,
    input  logic [31:0]           loadData
);

    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    // Counter is preloaded so that the exit edge lands exactly LATENCY edges
    // after the request-sampling edge.
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            counter;
    logic [3:0]            counter_next;

    logic [31:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_oor;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           word_data;
    logic                  word_oor;

    logic                  capture;
    logic                  proto_hit;
    logic                  load_we;
    logic                  commit_we;
    logic                  rd_done;
    logic                  wr_done;

    logic [31:0]           ram_in_q;
    logic                  read_ack_q;
    logic                  write_ack_q;
    logic                  addr_err_q;
    logic                  proto_err_q;

    // Byte-lane bits are not used by a word-wide memory.
    logic                  unused_lane_bits;

    assign unused_lane_bits = ^bus.ramAddress[1:0];

    assign req_idx = bus.ramAddress[DEPTH_LOG2+1:2];
    assign req_oor = |bus.ramAddress[31:DEPTH_LOG2+2];

    assign bus.ramIn    = ram_in_q;
    assign bus.readAck  = read_ack_q;
    assign bus.writeAck = write_ack_q;
    assign bus.addrErr  = addr_err_q;
    assign bus.protoErr = proto_err_q;
    assign bus.busy     = (state != IDLE);

    // Next-state and per-cycle strobes. A simultaneous read+write request is
    // served as a write (the read is dropped) and flagged; any request seen in
    // a wait state is ignored but flagged. Side loads only happen in quiet IDLE.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        capture      = 1'b0;
        proto_hit    = 1'b0;
        load_we      = 1'b0;
        commit_we    = 1'b0;
        rd_done      = 1'b0;
        wr_done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.writeReq) begin
                    state_next   = WR_WAIT;
                    counter_next = COUNT_LOAD;
                    capture      = 1'b1;
                    proto_hit    = bus.readReq;
                end else if (bus.readReq) begin
                    state_next   = RD_WAIT;
                    counter_next = COUNT_LOAD;
                    capture      = 1'b1;
                end else if (loadEn) begin
                    load_we = 1'b1;
                end
            end
            RD_WAIT: begin
                proto_hit = bus.readReq | bus.writeReq;
                if (counter == 4'd0) begin
                    state_next = IDLE;
                    rd_done    = 1'b1;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end
            WR_WAIT: begin
                proto_hit = bus.readReq | bus.writeReq;
                if (counter == 4'd0) begin
                    state_next = IDLE;
                    wr_done    = 1'b1;
                    commit_we  = ~word_oor;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, captured request and registered outputs. Acks and addrErr are
    // re-evaluated every cycle so they can only ever be one cycle wide; ramIn
    // only changes when a read completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= 4'd0;
            word_idx    <= '0;
            word_data   <= 32'd0;
            word_oor    <= 1'b0;
            ram_in_q    <= 32'd0;
            read_ack_q  <= 1'b0;
            write_ack_q <= 1'b0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            read_ack_q  <= rd_done;
            write_ack_q <= wr_done;
            addr_err_q  <= (rd_done | wr_done) & word_oor;
            if (capture) begin
                word_idx  <= req_idx;
                word_data <= bus.ramOut;
                word_oor  <= req_oor;
            end
            if (rd_done) begin
                ram_in_q <= word_oor ? OOR_DATA : mem[word_idx];
            end
            if (proto_hit) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Word array, deliberately without reset. Writes commit only on the exit
    // edge, so a reset mid-transaction leaves the array untouched.
    always_ff @(posedge clk) begin
        if (commit_we) begin
            mem[word_idx] <= word_data;
        end else if (load_we) begin
            mem[loadAddr] <= loadData;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
//   Self-checking bench for ram_responder. The main instance (LATENCY=2) is
//   exercised with directed vectors; expected acks are queued at issue time
//   and a separate monitor pops and compares each ack. Two more instances
//   (LATENCY=1 and 4) run the same tiny fetch/execute program and must end
//   with identical register values.
module tb_ram_responder;

    localparam int MAIN_LAT = 2;

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        loadEn;
    logic [9:0]  loadAddr;
    logic [31:0] loadData;

    exp_t        sbQueue[$];
    int          vectorCount = 0;
    int          missCount   = 0;

    ram_responder_if bus0 ();
    ram_responder_if bus1 ();
    ram_responder_if bus4 ();

    always #5 clk = ~clk;

    ram_responder #(.DEPTH_LOG2(10), .LATENCY(MAIN_LAT), .OOR_DATA(32'hdeadbeef)) dut (
        .clk(clk), .reset(reset), .bus(bus0),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    ram_responder #(.DEPTH_LOG2(10), .LATENCY(1), .OOR_DATA(32'hdeadbeef)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    ram_responder #(.DEPTH_LOG2(10), .LATENCY(4), .OOR_DATA(32'hdeadbeef)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expectAck(input bit isRead, input logic [31:0] data, input bit err);
        exp_t e;
        e.isRead = isRead;
        e.data   = data;
        e.err    = err;
        sbQueue.push_back(e);
    endtask

    // Called at a negedge; drives one request, checks busy, waits for the ack
    // and checks its latency. Returns at the negedge of the ack cycle so a
    // following call issues back-to-back.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string name);
        bit seen;
        int lat;
        bus0.ramAddress = addr;
        bus0.ramOut     = wdata;
        bus0.readReq    = rd;
        bus0.writeReq   = wr;
        @(negedge clk);
        bus0.readReq  = 1'b0;
        bus0.writeReq = 1'b0;
        checkOutput({name, "_busy"}, 32'(bus0.busy), 32'd1);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (bus0.readAck || bus0.writeAck) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            checkOutput({name, "_ackTimeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, "_latency"}, 32'(lat), 32'(MAIN_LAT));
            checkOutput({name, "_idleOnAck"}, 32'(bus0.busy), 32'd0);
        end
    endtask

    task automatic loadWord(input logic [9:0] a, input logic [31:0] d);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = d;
        @(negedge clk);
        loadEn = 1'b0;
    endtask

    // One bus access on the LATENCY=1 (sel=1) or LATENCY=4 (sel=4) instance.
    task automatic coreAccess(input int sel, input bit isWrite, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        bit seen;
        if (sel == 1) begin
            bus1.ramAddress = addr; bus1.ramOut = wdata;
            bus1.readReq = ~isWrite; bus1.writeReq = isWrite;
        end else begin
            bus4.ramAddress = addr; bus4.ramOut = wdata;
            bus4.readReq = ~isWrite; bus4.writeReq = isWrite;
        end
        @(negedge clk);
        bus1.readReq = 1'b0; bus1.writeReq = 1'b0;
        bus4.readReq = 1'b0; bus4.writeReq = 1'b0;
        seen  = 1'b0;
        lat   = -1;
        rdata = 32'd0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if ((sel == 1 && (bus1.readAck || bus1.writeAck)) ||
                (sel == 4 && (bus4.readAck || bus4.writeAck))) begin
                seen  = 1'b1;
                lat   = k;
                rdata = (sel == 1) ? bus1.ramIn : bus4.ramIn;
            end
        end
    endtask

    // Tiny core: op[31:28] 0=halt, 1 r0+=mem, 2 r1^=mem, 3 mem=r0; addr[11:0].
    task automatic runProgram(input int sel, output logic [31:0] r0, output logic [31:0] r1,
                              output bit ok);
        logic [31:0] instr;
        logic [31:0] d;
        int          lat;
        bit          halted;
        r0 = 32'd0;
        r1 = 32'd0;
        ok = 1'b1;
        halted = 1'b0;
        for (int pc = 0; pc < 16 && !halted; pc++) begin
            coreAccess(sel, 1'b0, 32'(pc * 4), 32'd0, instr, lat);
            if (lat != sel) ok = 1'b0;
            case (instr[31:28])
                4'd0: halted = 1'b1;
                4'd1: begin coreAccess(sel, 1'b0, {20'd0, instr[11:0]}, 32'd0, d, lat); r0 = r0 + d; end
                4'd2: begin coreAccess(sel, 1'b0, {20'd0, instr[11:0]}, 32'd0, d, lat); r1 = r1 ^ d; end
                4'd3: coreAccess(sel, 1'b1, {20'd0, instr[11:0]}, r0, d, lat);
                default: ok = 1'b0;
            endcase
            if (instr[31:28] != 4'd0 && lat != sel) ok = 1'b0;
        end
        if (!halted) ok = 1'b0;
    endtask

    // Scoreboard monitor for the main instance.
    initial begin : monitor
        bit   prevAck;
        exp_t e;
        prevAck = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevAck = 1'b0;
            end else if (bus0.readAck || bus0.writeAck) begin
                checkOutput("ackPulseWidth", 32'(prevAck), 32'd0);
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedAck", 32'({bus0.readAck, bus0.writeAck}), 32'd0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("ackKind", 32'({bus0.readAck, bus0.writeAck}),
                                e.isRead ? 32'd2 : 32'd1);
                    if (e.isRead) checkOutput("readData", bus0.ramIn, e.data);
                    checkOutput("addrErr", 32'(bus0.addrErr), 32'(e.err));
                end
                prevAck = 1'b1;
            end else begin
                prevAck = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] prog [7];
        logic [31:0] r0;
        logic [31:0] r1;
        bit          ok;
        bit          seen;

        reset    = 1'b1;
        loadEn   = 1'b0;
        loadAddr = 10'd0;
        loadData = 32'd0;
        bus0.ramAddress = 32'd0; bus0.ramOut = 32'd0; bus0.readReq = 1'b0; bus0.writeReq = 1'b0;
        bus1.ramAddress = 32'd0; bus1.ramOut = 32'd0; bus1.readReq = 1'b0; bus1.writeReq = 1'b0;
        bus4.ramAddress = 32'd0; bus4.ramOut = 32'd0; bus4.readReq = 1'b0; bus4.writeReq = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("resetRamIn", bus0.ramIn, 32'd0);
        checkOutput("resetAcks", 32'({bus0.readAck, bus0.writeAck}), 32'd0);
        checkOutput("resetBusy", 32'(bus0.busy), 32'd0);
        checkOutput("resetAddrErr", 32'(bus0.addrErr), 32'd0);
        checkOutput("resetProtoErr", 32'(bus0.protoErr), 32'd0);

        $display("[TB] preload and read");
        loadWord(10'd3, 32'h12345678);
        expectAck(1'b1, 32'h12345678, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_000c, 32'd0, "t1Read");

        $display("[TB] write then back-to-back reads");
        expectAck(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hcafef00d, "t2Write");
        expectAck(1'b1, 32'hcafef00d, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, "t2Read");
        expectAck(1'b1, 32'hcafef00d, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0011, 32'd0, "t2ReadLane");

        $display("[TB] out-of-range accesses");
        loadWord(10'd0, 32'ha5a5a5a5);
        expectAck(1'b1, 32'hdeadbeef, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'd0, "t3OorRead");
        expectAck(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0099, "t3OorWrite");
        checkOutput("t3RamInHold", bus0.ramIn, 32'hdeadbeef);
        checkOutput("t3NoProto", 32'(bus0.protoErr), 32'd0);
        expectAck(1'b1, 32'ha5a5a5a5, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'd0, "t3Word0Intact");

        $display("[TB] read and write together");
        expectAck(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0001, "t4Both");
        checkOutput("t4ProtoSet", 32'(bus0.protoErr), 32'd1);
        expectAck(1'b1, 32'h0000_0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0, "t4ReadBack");
        checkOutput("t4ProtoSticky", 32'(bus0.protoErr), 32'd1);

        $display("[TB] reset during a write");
        loadWord(10'd9, 32'h0000_0011);
        bus0.ramAddress = 32'h0000_0024;
        bus0.ramOut     = 32'h0000_0055;
        bus0.writeReq   = 1'b1;
        @(negedge clk);
        bus0.writeReq = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("t5ProtoCleared", 32'(bus0.protoErr), 32'd0);
        checkOutput("t5RamInCleared", bus0.ramIn, 32'd0);
        checkOutput("t5Idle", 32'(bus0.busy), 32'd0);

        // A write request arriving mid-read must be ignored and flagged.
        expectAck(1'b1, 32'h0000_0011, 1'b0);
        bus0.ramAddress = 32'h0000_0024;
        bus0.readReq    = 1'b1;
        @(negedge clk);
        bus0.readReq  = 1'b0;
        bus0.ramOut   = 32'h0000_0077;
        bus0.writeReq = 1'b1;
        @(negedge clk);
        bus0.writeReq = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus0.readAck || bus0.writeAck) seen = 1'b1;
        end
        checkOutput("t5AckSeen", 32'(seen), 32'd1);
        checkOutput("t5BusyProto", 32'(bus0.protoErr), 32'd1);
        expectAck(1'b1, 32'h0000_0011, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0024, 32'd0, "t5OldValue");

        $display("[TB] fetch loop at LATENCY 1 and 4");
        prog[0] = 32'h1000_0040;
        prog[1] = 32'h2000_0044;
        prog[2] = 32'h1000_0044;
        prog[3] = 32'h3000_0048;
        prog[4] = 32'h1000_0048;
        prog[5] = 32'h2000_0048;
        prog[6] = 32'h0000_0000;
        for (int i = 0; i < 7; i++) loadWord(10'(i), prog[i]);
        loadWord(10'd16, 32'h0000_0005);
        loadWord(10'd17, 32'h0000_00f0);
        loadWord(10'd18, 32'h0000_0000);

        runProgram(1, r0, r1, ok);
        checkOutput("t6Lat1R0", r0, 32'h0000_01ea);
        checkOutput("t6Lat1R1", r1, 32'h0000_0005);
        checkOutput("t6Lat1Timing", 32'(ok), 32'd1);
        runProgram(4, r0, r1, ok);
        checkOutput("t6Lat4R0", r0, 32'h0000_01ea);
        checkOutput("t6Lat4R1", r1, 32'h0000_0005);
        checkOutput("t6Lat4Timing", 32'(ok), 32'd1);

        repeat (5) @(negedge clk);
        checkOutput("sbDrain", 32'(sbQueue.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
